// File: rtl/label_watch_sequencer_if.sv
// -----------------------------------------------------------------------------
// label_watch_sequencer_if
// Purpose : bundles the retire-watch bus and the uPC redirect handshake that
//           run between the control unit and label_watch_sequencer.
// Signals : i_retire      one-cycle instruction-retired pulse
//           i_pc_x        PC at execution stage
//           i_pc_f        PC at fetch stage
//           i_opcode_x    opcode at execution stage, bits [112:1]
//           i_jump_ack    control unit has loaded o_jump_target
//           o_jump        redirect request, held until acknowledged
//           o_jump_target redirect address
// Modports: master - control-unit side (drives retire bus, answers redirects)
//           slave  - sequencer side (watches retires, issues redirects)
// -----------------------------------------------------------------------------
interface label_watch_sequencer_if #(
    parameter int PC_W = 12
);
    logic              i_retire;
    logic [PC_W-1:0]   i_pc_x;
    logic [PC_W-1:0]   i_pc_f;
    logic [112:1]      i_opcode_x;
    logic              i_jump_ack;
    logic              o_jump;
    logic [PC_W-1:0]   o_jump_target;

    modport master (
        output i_retire, i_pc_x, i_pc_f, i_opcode_x, i_jump_ack,
        input  o_jump, o_jump_target
    );

    modport slave (
        input  i_retire, i_pc_x, i_pc_f, i_opcode_x, i_jump_ack,
        output o_jump, o_jump_target
    );
endinterface

// File: rtl/label_watch_sequencer.sv
// -----------------------------------------------------------------------------
// label_watch_sequencer
// Purpose : microcode-test supervisor. Watches every retired microinstruction,
//           matches it against a runtime-loaded table of label watchers and
//           reports passes, failure, completion and timeout. JUMP watchers
//           issue a uPC reload request to the control unit with an ack.
// Ports   : clk, reset     clock, synchronous active-high reset
//           i_start        leave IDLE and begin supervision
//           i_limit        cycle limit sampled on start (0 = no limit)
//           i_cfg_*        table write port, honoured in IDLE only
//           bus            retire bus + redirect handshake (slave modport)
//           o_pass         one-cycle pass pulse, o_pass_idx valid with it
//           o_pass_mask    sticky set of PASS entries that matched
//           o_state        IDLE=0 RUN=1 REDIR=2 PASSED=3 FAILED=4 TIMEOUT=5
//           o_retired      saturating count of retires seen in RUN/REDIR
// -----------------------------------------------------------------------------
module label_watch_sequencer #(
    parameter int N_WATCH = 16,
    parameter int PC_W    = 12,
    parameter int CNT_W   = 32,
    localparam int IDX_W  = (N_WATCH > 1) ? $clog2(N_WATCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_limit,
    input  logic                 i_cfg_we,
    input  logic [IDX_W-1:0]     i_cfg_idx,
    input  logic [2:0]           i_cfg_mode,
    input  logic [PC_W-1:0]      i_cfg_from,
    input  logic [PC_W-1:0]      i_cfg_to,
    input  logic [PC_W-1:0]      i_cfg_target,
    label_watch_sequencer_if.slave bus,
    output logic                 o_pass,
    output logic [IDX_W-1:0]     o_pass_idx,
    output logic [N_WATCH-1:0]   o_pass_mask,
    output logic [2:0]           o_state,
    output logic [CNT_W-1:0]     o_retired
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_REDIR   = 3'd2,
        S_PASSED  = 3'd3,
        S_FAILED  = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam logic [2:0] M_OFF  = 3'd0;
    localparam logic [2:0] M_PASS = 3'd1;
    localparam logic [2:0] M_JUMP = 3'd2;
    localparam logic [2:0] M_FAIL = 3'd3;
    localparam logic [2:0] M_DONE = 3'd4;

    // The PASS label field is 12 bits wide; compare at the wider of the two.
    localparam int CMP_W = (PC_W > 12) ? PC_W : 12;

    state_t              r_state;
    logic                r_jump;
    logic [PC_W-1:0]     r_jump_target;

    logic [2:0]          r_mode   [N_WATCH];
    logic [PC_W-1:0]     r_from   [N_WATCH];
    logic [PC_W-1:0]     r_to     [N_WATCH];
    logic [PC_W-1:0]     r_target [N_WATCH];

    logic [CNT_W-1:0]    r_cycles;
    logic [CNT_W-1:0]    r_limit;
    logic [CNT_W-1:0]    r_retired;
    logic                r_pass;
    logic [IDX_W-1:0]    r_pass_idx;
    logic [N_WATCH-1:0]  r_pass_mask;

    logic                w_eval;
    logic                w_active;
    logic                w_timeout;
    logic                w_sqi_ok;
    logic [N_WATCH-1:0]  w_pass_hits;
    logic                w_pass_any;
    logic [IDX_W-1:0]    w_pass_idx;
    logic                w_jump_any;
    logic [PC_W-1:0]     w_jump_tgt;
    logic                w_fail_any;
    logic                w_done_any;
    logic                w_pass_nxt;
    state_t              w_state_nxt;
    logic                w_jump_nxt;
    logic [PC_W-1:0]     w_tgt_nxt;

    // Low opcode bits are not part of any watch rule.
    wire w_unused = ^bus.i_opcode_x[94:1];

    assign w_eval   = (r_state == S_RUN) && bus.i_retire;
    assign w_active = (r_state == S_RUN) || (r_state == S_REDIR);
    // ">=" rather than "==" so a timeout deferred by a same-cycle match is
    // still caught on a later cycle.
    assign w_timeout = (r_limit != '0) && (r_cycles >= r_limit - CNT_W'(1));
    assign w_sqi_ok  = (bus.i_opcode_x[112:109] == 4'd14) &&
                       (bus.i_opcode_x[96:95] == 2'd0);

    // Match scan runs from the top index down so the lowest index is the
    // last writer and therefore wins within a mode.
    always_comb begin
        w_pass_hits = '0;
        w_pass_any  = 1'b0;
        w_pass_idx  = '0;
        w_jump_any  = 1'b0;
        w_jump_tgt  = '0;
        w_fail_any  = 1'b0;
        w_done_any  = 1'b0;
        if (w_eval) begin
            for (int i = N_WATCH - 1; i >= 0; i--) begin
                case (r_mode[i])
                    M_PASS: begin
                        if (w_sqi_ok && (CMP_W'(bus.i_opcode_x[108:97]) == CMP_W'(r_from[i]))) begin
                            w_pass_hits[i] = 1'b1;
                            w_pass_any     = 1'b1;
                            w_pass_idx     = IDX_W'(i);
                        end
                    end
                    M_JUMP: begin
                        if ((bus.i_pc_x == r_from[i]) && (bus.i_pc_f == r_to[i])) begin
                            w_jump_any = 1'b1;
                            w_jump_tgt = r_target[i];
                        end
                    end
                    M_FAIL: if (bus.i_pc_x == r_from[i]) w_fail_any = 1'b1;
                    M_DONE: if (bus.i_pc_x == r_from[i]) w_done_any = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // A pass only pulses when no state-changing event claims the retire.
    assign w_pass_nxt = w_pass_any && !w_fail_any && !w_jump_any && !w_done_any;

    always_comb begin
        w_state_nxt = r_state;
        w_jump_nxt  = r_jump;
        w_tgt_nxt   = r_jump_target;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_fail_any) begin
                    w_state_nxt = S_FAILED;
                end else if (w_jump_any) begin
                    w_state_nxt = S_REDIR;
                    w_jump_nxt  = 1'b1;
                    w_tgt_nxt   = w_jump_tgt;
                end else if (w_done_any) begin
                    w_state_nxt = S_PASSED;
                end else if (w_timeout) begin
                    w_state_nxt = S_TIMEOUT;
                end
            end
            S_REDIR: begin
                if (w_timeout) begin
                    w_state_nxt = S_TIMEOUT;
                    w_jump_nxt  = 1'b0;
                end else if (bus.i_jump_ack) begin
                    w_state_nxt = S_RUN;
                    w_jump_nxt  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_jump        <= 1'b0;
            r_jump_target <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_jump        <= w_jump_nxt;
            r_jump_target <= w_tgt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_WATCH; i++) begin
                r_mode[i]   <= M_OFF;
                r_from[i]   <= '0;
                r_to[i]     <= '0;
                r_target[i] <= '0;
            end
            r_cycles    <= '0;
            r_limit     <= '0;
            r_retired   <= '0;
            r_pass      <= 1'b0;
            r_pass_idx  <= '0;
            r_pass_mask <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (i_cfg_we && (int'(i_cfg_idx) < N_WATCH)) begin
                    r_mode[i_cfg_idx]   <= i_cfg_mode;
                    r_from[i_cfg_idx]   <= i_cfg_from;
                    r_to[i_cfg_idx]     <= i_cfg_to;
                    r_target[i_cfg_idx] <= i_cfg_target;
                end
                if (i_start) begin
                    r_cycles <= '0;
                    r_limit  <= i_limit;
                end
            end
            if (w_active) begin
                r_cycles <= r_cycles + CNT_W'(1);
                if (bus.i_retire && !(&r_retired)) r_retired <= r_retired + CNT_W'(1);
            end
            r_pass <= w_pass_nxt;
            if (w_pass_nxt) r_pass_idx <= w_pass_idx;
            r_pass_mask <= r_pass_mask | w_pass_hits;
        end
    end

    assign bus.o_jump        = r_jump;
    assign bus.o_jump_target = r_jump_target;
    assign o_pass            = r_pass;
    assign o_pass_idx        = r_pass_idx;
    assign o_pass_mask       = r_pass_mask;
    assign o_state           = r_state;
    assign o_retired         = r_retired;

endmodule
